multiplicador_secuencial_7bits: RTL and testbench

Sequential shift-and-add multiplier-accumulator, 7-bit × 7-bit + 7-bit → 14-bit, computing producto = multiplicando × multiplicador + sumando. It is the inverse datapath of the restoring divider. It reconstructs a dividend from (cociente, divisor, resto) for self-check and round-trip paths, and also serves as a general small multiplier. It uses the same start/done handshake style as the other iterative arithmetic blocks: one operation in flight, fixed latency.

---
 rtl/multiplicador_secuencial_7bits.sv | 123 ++++++++++++
 tb/tb_multiplicador_secuencial_7bits.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_secuencial_7bits.sv
// Sequential shift-and-add multiplier-accumulator:
//   producto = multiplicando * multiplicador + sumando  (7b x 7b + 7b -> 14b, unsigned)
// Rebuilds a dividend from (cociente, divisor, resto) for round-trip checks, and
// doubles as a small general-purpose multiplier.
//
// Handshake: start_i is sampled only while the FSM is IDLE; the accepting edge
// captures all three operands, which may change freely afterwards. Exactly one
// operation is in flight. done_o pulses for one cycle 9 edges after acceptance,
// in a cycle where busy_o is already low. Requests seen while busy are dropped.
// producto_o is registered and only changes on that completing edge.
module multiplicador_secuencial_7bits (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [6:0]  multiplicando_i,
    input  logic [6:0]  multiplicador_i,
    input  logic [6:0]  sumando_i,
    output logic [13:0] producto_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;           // accumulator, bit 7 catches the add carry
    logic [6:0]  q_q, q_d;           // multiplier, shifted right; low product bits enter from the top
    logic [6:0]  m_q, m_d;
    logic [6:0]  s_q, s_d;
    logic [2:0]  count_q, count_d;
    logic [13:0] producto_q, producto_d;
    logic        done_q, done_d;
    logic [7:0]  step_sum;

    // Conditional add of the multiplicand; A <= 127 before the add so 8 bits never overflow.
    assign step_sum = q_q[0] ? (a_q + {1'b0, m_q}) : a_q;

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values; everything holds unless its state updates it.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        q_d        = q_q;
        m_d        = m_q;
        s_d        = s_q;
        count_d    = count_q;
        producto_d = producto_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    m_d     = multiplicando_i;
                    q_d     = multiplicador_i;
                    s_d     = sumando_i;
                end
            end
            LOAD: begin
                a_d     = 8'd0;
                count_d = 3'd0;
                state_d = STEP;
            end
            STEP: begin
                // 15-bit right shift of {carry, sum, Q}: sum LSB drops into Q[6].
                a_d     = {1'b0, step_sum[7:1]};
                q_d     = {step_sum[0], q_q[6:1]};
                count_d = count_q + 3'd1;
                if (count_q == 3'd6) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                producto_d = {a_q[6:0], q_q} + {7'b0, s_q};
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and result registers; reset clears everything so an aborted op leaves no trace.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q        <= 8'd0;
            q_q        <= 7'd0;
            m_q        <= 7'd0;
            s_q        <= 7'd0;
            count_q    <= 3'd0;
            producto_q <= 14'd0;
            done_q     <= 1'b0;
        end else begin
            a_q        <= a_d;
            q_q        <= q_d;
            m_q        <= m_d;
            s_q        <= s_d;
            count_q    <= count_d;
            producto_q <= producto_d;
            done_q     <= done_d;
        end
    end

    assign producto_o = producto_q;
    assign done_o     = done_q;
    assign busy_o     = (state_q != IDLE);
    assign state_o    = state_q;

endmodule

// File: tb/tb_multiplicador_secuencial_7bits.sv
// Directed bench for multiplicador_secuencial_7bits: reset/idle, single
// operations with cycle-exact done timing, start-while-busy, back-to-back
// and reset in the middle of an operation.
module tb_multiplicador_secuencial_7bits;

    logic        clk;
    logic        rst;
    logic        start;
    logic [6:0]  multiplicando;
    logic [6:0]  multiplicador;
    logic [6:0]  sumando;
    logic [13:0] producto;
    logic        busy;
    logic        done;
    logic [1:0]  state;

    int checks;
    int errors;
    logic [13:0] exp_prod;   // last completed result the bench expects to see held

    multiplicador_secuencial_7bits dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start),
        .multiplicando_i (multiplicando),
        .multiplicador_i (multiplicador),
        .sumando_i       (sumando),
        .producto_o      (producto),
        .busy_o          (busy),
        .done_o          (done),
        .state_o         (state)
    );

    // Clock: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation: accept on the next edge (k), then check every edge up to k+9.
    task automatic run_op(input logic [6:0] m, input logic [6:0] q, input logic [6:0] s,
                          input logic [13:0] exp, input string name);
        multiplicando = m;
        multiplicador = q;
        sumando       = s;
        start         = 1'b1;
        tick();
        start         = 1'b0;
        multiplicando = 7'h55;
        multiplicador = 7'h2a;
        sumando       = 7'h7f;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy after accept: got %b want 1", name, busy);
        end
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (e < 9) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b1 || producto !== exp_prod) begin
                    errors++;
                    $display("FAIL %s in-flight edge k+%0d: done=%b busy=%b producto=%0d want done=0 busy=1 producto=%0d",
                             name, e, done, busy, producto, exp_prod);
                end
            end else begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done timing at k+9: done=%b busy=%b want done=1 busy=0", name, done, busy);
                end
                checks++;
                if (producto !== exp) begin
                    errors++;
                    $display("FAIL %s producto: got %0d want %0d", name, producto, exp);
                end
                exp_prod = exp;
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || producto !== exp) begin
            errors++;
            $display("FAIL %s after done: done=%b busy=%b producto=%0d want 0 0 %0d", name, done, busy, producto, exp);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        start         = 1'b0;
        multiplicando = 7'd0;
        multiplicador = 7'd0;
        sumando       = 7'd0;
        exp_prod      = 14'd0;
        repeat (3) tick();
        checks++;
        if (producto !== 14'd0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: producto=%0d done=%b busy=%b want 0 0 0", producto, done, busy);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (producto !== 14'd0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_cycle_%0d: producto=%0d done=%b busy=%b want 0 0 0", i, producto, done, busy);
            end
        end
    endtask

    task automatic test_round_trip();
        run_op(7'd6, 7'd13, 7'd5, 14'd83, "round_trip");
    endtask

    task automatic test_extremes();
        run_op(7'd127, 7'd127, 7'd127, 14'd16256, "max");
        run_op(7'd0,   7'd127, 7'd0,   14'd0,     "zero_m");
        run_op(7'd127, 7'd0,   7'd127, 14'd127,   "zero_q");
        run_op(7'd1,   7'd1,   7'd0,   14'd1,     "one");
        run_op(7'd3,   7'd5,   7'd0,   14'd15,    "odd_q");
    endtask

    task automatic test_start_during_busy();
        multiplicando = 7'd10;
        multiplicador = 7'd10;
        sumando       = 7'd0;
        start         = 1'b1;
        tick();                       // edge k
        start = 1'b0;
        tick();                       // k+1
        tick();                       // k+2
        tick();                       // k+3
        multiplicando = 7'd3;
        multiplicador = 7'd3;
        sumando       = 7'd3;
        start         = 1'b1;
        tick();                       // k+4 sees the ignored request
        start = 1'b0;
        for (int e = 5; e <= 9; e++) begin
            tick();
            if (e < 9) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_ignore k+%0d: done=%b busy=%b want 0 1", e, done, busy);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || producto !== 14'd100) begin
            errors++;
            $display("FAIL busy_ignore result: done=%b producto=%0d want 1 100", done, producto);
        end
        exp_prod = 14'd100;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || producto !== 14'd100) begin
                errors++;
                $display("FAIL busy_ignore no_second_op %0d: done=%b busy=%b producto=%0d want 0 0 100",
                         i, done, busy, producto);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        multiplicando = 7'd5;
        multiplicador = 7'd7;
        sumando       = 7'd2;
        start         = 1'b1;
        tick();                       // first acceptance
        // Each operation occupies LOAD, 7xSTEP, FIN, then one IDLE cycle (the done cycle).
        for (int e = 1; e <= 29; e++) begin
            tick();
            exp_done = ((e % 10) == 9);
            if (e == 9) exp_prod = 14'd37;
            checks++;
            if (done !== exp_done || busy !== !exp_done || producto !== exp_prod) begin
                errors++;
                $display("FAIL back_to_back edge %0d: done=%b busy=%b producto=%0d want %b %b %0d",
                         e, done, busy, producto, exp_done, !exp_done, exp_prod);
            end
            if (e == 29) start = 1'b0;
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back stop: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_op();
        multiplicando = 7'd100;
        multiplicador = 7'd100;
        sumando       = 7'd0;
        start         = 1'b1;
        tick();                       // edge k
        start = 1'b0;
        repeat (4) tick();            // k+1 .. k+4
        @(posedge clk);               // k+5
        rst = 1'b0;
        #1;
        exp_prod = 14'd0;
        checks++;
        if (producto !== 14'd0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset immediate: producto=%0d done=%b busy=%b want 0 0 0", producto, done, busy);
        end
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || producto !== 14'd0) begin
                errors++;
                $display("FAIL mid_reset no_done %0d: done=%b busy=%b producto=%0d want 0 0 0", i, done, busy, producto);
            end
        end
        run_op(7'd2, 7'd3, 7'd1, 14'd7, "after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_round_trip();
        test_extremes();
        test_start_during_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
